// File: rtl/mem_wb_stage.sv
// mem_wb_stage: back end of the 16-bit pipelined CPU.
// Holds the EX/MEM and MEM/WB pipeline registers and owns the data memory.
// Drives the register-file write port and exposes EX/MEM state to the
// forwarding and hazard logic. All state changes on the falling clock edge.
module mem_wb_stage #(
  parameter int DATA_W     = 16,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [1:0]        ex_wr,
  input  logic              ex_reg_write,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_halt,
  output logic [1:0]        exmem_wr,
  output logic              exmem_reg_write,
  output logic              exmem_is_load,
  output logic [DATA_W-1:0] exmem_alu_out,
  output logic              wb_reg_write,
  output logic [1:0]        wb_wr,
  output logic [DATA_W-1:0] wb_wd,
  output logic              halted,
  input  logic [DATA_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int IDX_W = $clog2(DMEM_DEPTH);

  // Data memory is deliberately not cleared by reset; words 0 and 1 come up
  // preloaded so programs have constants to load.
  logic [DATA_W-1:0] dmem [DMEM_DEPTH] = '{0: DATA_W'(5), 1: DATA_W'(7), default: '0};

  logic              exmem_mem_write;
  logic              exmem_halt;
  logic [DATA_W-1:0] exmem_store_data;
  logic              wb_reg_write_raw;

  logic              take;
  logic              freeze;
  logic [IDX_W-1:0]  mem_index;
  logic [IDX_W-1:0]  dbg_index;
  logic [DATA_W-1:0] load_data;
  logic              unused_dbg_bits;

  // A halt marker sitting in EX/MEM means halted rises on the coming edge,
  // so upstream input is already ignored on that edge.
  assign take      = ex_valid & ~ex_halt;
  assign freeze    = halted | exmem_halt;
  assign mem_index = exmem_alu_out[IDX_W:1];
  assign dbg_index = dbg_addr[IDX_W:1];
  assign load_data = dmem[mem_index];
  assign dbg_data  = dmem[dbg_index];

  assign unused_dbg_bits = ^{dbg_addr[0], dbg_addr[DATA_W-1:IDX_W+1]};

  // EX/MEM capture with control sanitising: stores never write a register,
  // $0 is never a write target, and bubbles/halts carry no control or data.
  always_ff @(negedge clock) begin
    if (reset) begin
      exmem_wr         <= '0;
      exmem_reg_write  <= 1'b0;
      exmem_is_load    <= 1'b0;
      exmem_alu_out    <= '0;
      exmem_mem_write  <= 1'b0;
      exmem_halt       <= 1'b0;
      exmem_store_data <= '0;
    end else if (!freeze) begin
      exmem_wr         <= take ? ex_wr : 2'd0;
      exmem_reg_write  <= take & ex_reg_write & ~ex_mem_write & (ex_wr != 2'd0);
      exmem_is_load    <= take & ex_mem_to_reg & ~ex_mem_write;
      exmem_alu_out    <= take ? ex_alu_out : '0;
      exmem_mem_write  <= take & ex_mem_write;
      exmem_halt       <= ex_valid & ex_halt;
      exmem_store_data <= take ? ex_store_data : '0;
    end
  end

  // Store commits as the entry leaves EX/MEM, so a load right behind it
  // already sees the new word; a reset on that edge drops the store.
  always_ff @(negedge clock) begin
    if (!reset && !halted && exmem_mem_write) begin
      dmem[mem_index] <= exmem_store_data;
    end
  end

  // MEM/WB capture and sticky halt; the register freezes once halted.
  always_ff @(negedge clock) begin
    if (reset) begin
      wb_reg_write_raw <= 1'b0;
      wb_wr            <= '0;
      wb_wd            <= '0;
      halted           <= 1'b0;
    end else if (!halted) begin
      wb_reg_write_raw <= exmem_reg_write;
      wb_wr            <= exmem_wr;
      wb_wd            <= exmem_is_load ? load_data : exmem_alu_out;
      halted           <= exmem_halt;
    end
  end

  assign wb_reg_write = wb_reg_write_raw & ~halted;

endmodule
